// File: rtl/tone_synth_pkg.sv
// Shared constants and helpers for the tone_synth multi-channel square-wave generator.
// Imported by the interface, the channel sub-module and the top level.
package tone_synth_pkg;

   localparam int MAX_CHANNELS = 8;

   // Half-periods in cycles for a 50 MHz clock.
   localparam int unsigned HP_C4 = 95555;
   localparam int unsigned HP_E4 = 75842;
   localparam int unsigned HP_G4 = 63775;

   // Half-period in cycles for a note given in hundredths of a hertz.
   function automatic int unsigned hp_of(input longint unsigned clock_hz,
                                         input longint unsigned freq_mul_100);
      if (freq_mul_100 == 0) return 0;
      return 32'((clock_hz * 100) / freq_mul_100 / 2);
   endfunction

   // Width of a channel index, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Controller-side bus of tone_synth: load/select/pitch/enable in, tones and mixer out.
// The duration/done signals exist only when TONE_SYNTH_DURATION_EN is defined.
interface tone_synth_if #(
   parameter int N_CHANNELS = 3,
   parameter int PERIOD_W   = 20
`ifdef TONE_SYNTH_DURATION_EN
   ,
   parameter int DUR_W      = 16
`endif
);
   import tone_synth_pkg::*;

   localparam int SEL_W = sel_width(N_CHANNELS);
   localparam int MIX_W = $clog2(N_CHANNELS + 1);

   logic                  load;
   logic [SEL_W-1:0]      ch_sel;
   logic [PERIOD_W-1:0]   half_period;
   logic [N_CHANNELS-1:0] ch_enable;
   logic [N_CHANNELS-1:0] tone;
   logic                  mix_or;
   logic [MIX_W-1:0]      mix_count;
`ifdef TONE_SYNTH_DURATION_EN
   logic [DUR_W-1:0]      duration;
   logic [N_CHANNELS-1:0] done;

   modport master (
      output load, ch_sel, half_period, ch_enable, duration,
      input  tone, mix_or, mix_count, done
   );
   modport slave (
      input  load, ch_sel, half_period, ch_enable, duration,
      output tone, mix_or, mix_count, done
   );
`else
   modport master (
      output load, ch_sel, half_period, ch_enable,
      input  tone, mix_or, mix_count
   );
   modport slave (
      input  load, ch_sel, half_period, ch_enable,
      output tone, mix_or, mix_count
   );
`endif

endinterface

// File: rtl/tone_synth_channel.sv
// One tone channel: programmable half-period divider with a registered square-wave output.
// With TONE_SYNTH_DURATION_EN it also counts down a note length in millisecond ticks.
module tone_synth_channel #(
   parameter int PERIOD_W = 20
`ifdef TONE_SYNTH_DURATION_EN
   ,
   parameter int DUR_W    = 16
`endif
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load_i,
   input  logic [PERIOD_W-1:0] half_period_i,
   input  logic                enable_i,
   output logic                tone_o
`ifdef TONE_SYNTH_DURATION_EN
   ,
   input  logic                tick_i,
   input  logic [DUR_W-1:0]    duration_i,
   output logic                done_o
`endif
);

   logic [PERIOD_W-1:0] hp_q, hp_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                tone_q, tone_d;
   logic [PERIOD_W-1:0] hp_run;
`ifdef TONE_SYNTH_DURATION_EN
   logic [DUR_W-1:0]    rem_q, rem_d;
   logic                done_q, done_d;
`endif

   // A load takes effect on the same edge, so the run decision sees the new half-period.
   assign hp_run = load_i ? half_period_i : hp_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      hp_d   = hp_q;
      cnt_d  = cnt_q;
      tone_d = tone_q;
`ifdef TONE_SYNTH_DURATION_EN
      rem_d  = rem_q;
      done_d = 1'b0;
`endif

      if (load_i) hp_d = half_period_i;

`ifdef TONE_SYNTH_DURATION_EN
      // Load outranks expiry: the fresh note starts and no done pulse is raised.
      if (load_i) begin
         rem_d = duration_i;
      end else if (tick_i && enable_i && (rem_q != '0)) begin
         rem_d = rem_q - 1'b1;
         if (rem_q == DUR_W'(1)) begin
            hp_d   = '0;
            done_d = 1'b1;
         end
      end
`endif

      if (!enable_i || (hp_run == '0)) begin
         cnt_d  = '0;
         tone_d = 1'b0;
      end else if (load_i) begin
         cnt_d  = '0;
      end else if (cnt_q == hp_q - 1'b1) begin
         cnt_d  = '0;
         tone_d = ~tone_q;
      end else begin
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hp_q   <= '0;
         cnt_q  <= '0;
         tone_q <= 1'b0;
`ifdef TONE_SYNTH_DURATION_EN
         rem_q  <= '0;
         done_q <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         hp_q   <= hp_d;
         cnt_q  <= cnt_d;
         tone_q <= tone_d;
`ifdef TONE_SYNTH_DURATION_EN
         rem_q  <= rem_d;
         done_q <= done_d;
`endif
      end
   end

   assign tone_o = tone_q;
`ifdef TONE_SYNTH_DURATION_EN
   assign done_o = done_q;
`endif

endmodule

// File: rtl/tone_synth.sv
// Multi-channel square-wave tone generator with an OR/popcount mixer.
// Define TONE_SYNTH_DURATION_EN to add per-note millisecond durations and done pulses.
module tone_synth
   import tone_synth_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 50000000,
   parameter int N_CHANNELS      = 3,
   parameter int PERIOD_W        = 20,
   parameter int DUR_W           = 16
) (
   input  logic          clock,
   input  logic          reset,
   tone_synth_if.slave   bus
);

   localparam int SEL_W = sel_width(N_CHANNELS);
   localparam int MIX_W = $clog2(N_CHANNELS + 1);

   if (N_CHANNELS < 1 || N_CHANNELS > MAX_CHANNELS || PERIOD_W < 1 ||
       DUR_W < 1 || CLOCK_FREQUENCY < 1) begin : g_bad_param
      $error("tone_synth: parameter out of range");
   end

   logic [N_CHANNELS-1:0] load_vec;
   logic [N_CHANNELS-1:0] tone_w;
   logic [MIX_W-1:0]      mix_cnt;

`ifdef TONE_SYNTH_DURATION_EN
   localparam int TICK_DIV = (CLOCK_FREQUENCY / 1000 < 1) ? 1 : CLOCK_FREQUENCY / 1000;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0]      pre_q, pre_d;
   logic                  tick;
   logic [N_CHANNELS-1:0] done_w;

   // Free-running millisecond prescaler; the tick is the last count of each period.
   assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
   assign pre_d = tick ? '0 : pre_q + 1'b1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pre_q <= '0;
      else       pre_q <= pre_d;
   end

   assign bus.done = done_w;
`endif

   // Select values with no matching channel decode to nothing, so such loads are dropped.
   for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
      assign load_vec[c] = bus.load && (bus.ch_sel == SEL_W'(c));

      tone_synth_channel #(
         .PERIOD_W      (PERIOD_W)
`ifdef TONE_SYNTH_DURATION_EN
         ,
         .DUR_W         (DUR_W)
`endif
      ) u_channel (
         .clock         (clock),
         .reset         (reset),
         .load_i        (load_vec[c]),
         .half_period_i (bus.half_period),
         .enable_i      (bus.ch_enable[c]),
         .tone_o        (tone_w[c])
`ifdef TONE_SYNTH_DURATION_EN
         ,
         .tick_i        (tick),
         .duration_i    (bus.duration),
         .done_o        (done_w[c])
`endif
      );
   end

   always_comb begin
      mix_cnt = '0;
      for (int c = 0; c < N_CHANNELS; c++) begin
         mix_cnt = mix_cnt + MIX_W'(tone_w[c]);
      end
   end

   assign bus.tone      = tone_w;
   assign bus.mix_or    = |tone_w;
   assign bus.mix_count = mix_cnt;

endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: vector table, directed corner cases and a
// randomized run against a phase-arithmetic reference model.
module tb_tone_synth;
   import tone_synth_pkg::*;

   localparam int NCH    = 3;
   localparam int PW     = 20;
   localparam int DW     = 16;
   localparam int CLK_HZ = 8000;

   logic clock = 1'b0;
   logic reset;

   tone_synth_if #(
      .N_CHANNELS (NCH),
      .PERIOD_W   (PW)
`ifdef TONE_SYNTH_DURATION_EN
      ,
      .DUR_W      (DW)
`endif
   ) bus ();

   tone_synth #(
      .CLOCK_FREQUENCY (CLK_HZ),
      .N_CHANNELS      (NCH),
      .PERIOD_W        (PW),
      .DUR_W           (DW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a running channel's tone is its starting level flipped once per
   // completed half-period since its start edge.
   int e;
   int m_hp   [NCH];
   bit m_act  [NCH];
   int m_s    [NCH];
   bit m_base [NCH];
   bit m_tone [NCH];

   task automatic model_clear();
      e = 0;
      for (int c = 0; c < NCH; c++) begin
         m_hp[c] = 0; m_act[c] = 0; m_s[c] = 0; m_base[c] = 0; m_tone[c] = 0;
      end
   endtask

   task automatic model_edge(input bit ld, input int sel, input int hp, input bit [NCH-1:0] en);
      for (int c = 0; c < NCH; c++) begin
         bit ldc;
         bit prev;
         ldc  = ld && (sel == c);
         prev = m_tone[c];
         if (ldc) m_hp[c] = hp;
         if (!en[c] || m_hp[c] == 0) begin
            m_tone[c] = 0;
            m_act[c]  = 0;
         end else if (ldc) begin
            m_s[c]    = e;
            m_base[c] = prev;
            m_act[c]  = 1;
         end else begin
            if (!m_act[c]) begin
               m_s[c]    = e - 1;
               m_base[c] = 0;
               m_act[c]  = 1;
            end
            m_tone[c] = m_base[c] ^ ((((e - m_s[c]) / m_hp[c]) % 2) == 1);
         end
      end
   endtask

   task automatic compare_model();
      logic [NCH-1:0] exp_t;
      int pop;
      pop = 0;
      for (int c = 0; c < NCH; c++) begin
         exp_t[c] = m_tone[c];
         pop += int'(m_tone[c]);
      end
      check("model_tone",      32'(bus.tone),      32'(exp_t));
      check("model_mix_count", 32'(bus.mix_count), 32'(pop));
      check("model_mix_or",    32'(bus.mix_or),    32'(pop != 0));
   endtask

   task automatic cycle(input bit ld, input int sel, input int hp, input bit [NCH-1:0] en,
                        input bit cmp);
      bus.load        = ld;
      bus.ch_sel      = sel[1:0];
      bus.half_period = PW'(hp);
      bus.ch_enable   = en;
      @(posedge clock);
      #1;
      e++;
      model_edge(ld, sel, hp, en);
      bus.load = 1'b0;
      if (cmp) compare_model();
   endtask

   typedef struct {
      bit           ld;
      int           sel;
      int           hp;
      bit [NCH-1:0] en;
      bit [NCH-1:0] tone;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation did not complete");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      bit           r_ld;
      int           r_sel;
      int           r_hp;
      bit [NCH-1:0] en_r;
      int           ones;
`ifdef TONE_SYNTH_DURATION_EN
      int           l_edge;
      int           t_exp;
`endif

      bus.load = 1'b0; bus.ch_sel = '0; bus.half_period = '0; bus.ch_enable = '0;
`ifdef TONE_SYNTH_DURATION_EN
      bus.duration = '0;
`endif
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_tone",      32'(bus.tone),      32'(0));
      check("reset_mix_count", 32'(bus.mix_count), 32'(0));
      check("reset_mix_or",    32'(bus.mix_or),    32'(0));
`ifdef TONE_SYNTH_DURATION_EN
      check("reset_done",      32'(bus.done),      32'(0));
`endif
      @(negedge clock);
      reset = 1'b0;
      model_clear();

      // ch0 H=4; ch1 H=0 then H=1; disable; enable-rise plus an out-of-range load.
      tbl.push_back('{1, 0, 4, 3'b001, 3'b000});
      repeat (3) tbl.push_back('{0, 0, 0, 3'b001, 3'b000});
      repeat (4) tbl.push_back('{0, 0, 0, 3'b001, 3'b001});
      repeat (4) tbl.push_back('{0, 0, 0, 3'b001, 3'b000});
      tbl.push_back('{0, 0, 0, 3'b001, 3'b001});
      tbl.push_back('{1, 1, 0, 3'b011, 3'b001});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b001});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b001});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b000});
      tbl.push_back('{1, 1, 1, 3'b011, 3'b000});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b010});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b000});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b011});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b001});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b011});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b001});
      tbl.push_back('{0, 0, 0, 3'b011, 3'b010});
      tbl.push_back('{0, 0, 0, 3'b000, 3'b000});
      tbl.push_back('{1, 3, 1, 3'b111, 3'b010});
      tbl.push_back('{0, 0, 0, 3'b111, 3'b000});
      tbl.push_back('{0, 0, 0, 3'b111, 3'b010});
      tbl.push_back('{0, 0, 0, 3'b111, 3'b001});

      foreach (tbl[i]) begin
         cycle(tbl[i].ld, tbl[i].sel, tbl[i].hp, tbl[i].en, 1'b1);
         check($sformatf("table_tone[%0d]", i), 32'(bus.tone), 32'(tbl[i].tone));
         check($sformatf("table_mix[%0d]", i),  32'(bus.mix_count), 32'($countones(tbl[i].tone)));
      end

      // Reload mid-count: H=6 at cnt=3, then H=2 keeps the level and toggles 2 edges later.
      cycle(0, 0, 0, 3'b000, 1'b1);
      cycle(1, 0, 6, 3'b001, 1'b1);
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 3'b001, 1'b1);
      check("reload_pre", 32'(bus.tone[0]), 32'(1));
      cycle(1, 0, 2, 3'b001, 1'b1);
      check("reload_keep", 32'(bus.tone[0]), 32'(1));
      cycle(0, 0, 0, 3'b001, 1'b1);
      check("reload_hold", 32'(bus.tone[0]), 32'(1));
      cycle(0, 0, 0, 3'b001, 1'b1);
      check("reload_toggle", 32'(bus.tone[0]), 32'(0));
      cycle(0, 0, 0, 3'b001, 1'b1);
      cycle(0, 0, 0, 3'b001, 1'b1);
      check("reload_second", 32'(bus.tone[0]), 32'(1));

      // Three channels at H=3,4,5, then drop enable of ch2.
      cycle(1, 0, 3, 3'b000, 1'b1);
      cycle(1, 1, 4, 3'b000, 1'b1);
      cycle(1, 2, 5, 3'b000, 1'b1);
      for (int i = 0; i < 40; i++) cycle(0, 0, 0, 3'b111, 1'b1);
      cycle(0, 0, 0, 3'b011, 1'b1);
      check("drop_en2", 32'(bus.tone[2]), 32'(0));

      en_r = 3'b011;
      for (int i = 0; i < 600; i++) begin
         r_ld  = ($urandom_range(0, 5) == 0);
         r_sel = $urandom_range(0, 3);
         r_hp  = $urandom_range(0, 6);
         if ($urandom_range(0, 19) == 0) en_r[$urandom_range(0, NCH - 1)] ^= 1'b1;
         cycle(r_ld, r_sel, r_hp, en_r, 1'b1);
      end

      // Asynchronous reset mid-run, then enabled channels stay silent until reloaded.
      cycle(1, 0, 1, 3'b111, 1'b1);
      cycle(0, 0, 0, 3'b111, 1'b1);
      check("pre_reset_running", 32'(bus.tone[0]), 32'(1));
      #3;
      reset = 1'b1;
      #1;
      check("async_reset_tone",  32'(bus.tone),      32'(0));
      check("async_reset_count", 32'(bus.mix_count), 32'(0));
      check("async_reset_or",    32'(bus.mix_or),    32'(0));
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      for (int i = 0; i < 12; i++) begin
         cycle(0, 0, 0, 3'b111, 1'b1);
         check("post_reset_silent", 32'(bus.tone), 32'(0));
      end

`ifdef TONE_SYNTH_DURATION_EN
      // Ticks land on edges 8, 16, 24... counted from reset release.
      bus.duration = DW'(3);
      cycle(1, 0, 2, 3'b001, 1'b0);
      bus.duration = '0;
      l_edge = e;
      t_exp  = (l_edge / 8 + 1) * 8 + 16;
      for (int i = 0; i < 40; i++) begin
         cycle(0, 0, 0, 3'b001, 1'b0);
         check("dur_done", 32'(bus.done[0]), 32'(e == t_exp));
         if (e > t_exp) check("dur_silent", 32'(bus.tone[0]), 32'(0));
      end

      bus.duration = DW'(2);
      cycle(1, 0, 2, 3'b001, 1'b0);
      bus.duration = '0;
      l_edge = e;
      t_exp  = (l_edge / 8 + 1) * 8 + 8;
      while (e < t_exp - 1) begin
         cycle(0, 0, 0, 3'b001, 1'b0);
         check("coinc_no_early_done", 32'(bus.done[0]), 32'(0));
      end
      bus.duration = DW'(5);
      cycle(1, 0, 3, 3'b001, 1'b0);
      bus.duration = '0;
      check("coinc_edge", 32'(e), 32'(t_exp));
      check("coinc_no_done", 32'(bus.done[0]), 32'(0));
      ones = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(0, 0, 0, 3'b001, 1'b0);
         check("coinc_no_done_after", 32'(bus.done[0]), 32'(0));
         ones += int'(bus.tone[0]);
      end
      check("coinc_still_running", 32'(ones > 0), 32'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
